// File: rtl/mc_pi_sampler.sv
// Monte Carlo pi estimator: draws (x, y) from two LFSRs, squares each coordinate with a
// serial shift-add loop and counts the samples that land inside the unit circle.
module mc_pi_sampler #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          cont_i,
    input  logic          stop_i,
    input  logic          hold_i,
    input  logic [CW-1:0] n_samples_i,
    input  logic          seed_load_i,
    input  logic [15:0]   seed_i,
    input  logic          force_en_i,
    input  logic [W-1:0]  force_x_i,
    input  logic [W-1:0]  force_y_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] total_o,
    output logic [CW-1:0] hits_o,
    output logic          sample_valid_o,
    output logic          sample_hit_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SQX  = 3'd2;
    localparam logic [2:0] S_SQY  = 3'd3;
    localparam logic [2:0] S_CMP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam int AW = 2 * W + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // An all-zero LFSR would lock up, so it is replaced by 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] v);
        return (v == 16'h0000) ? 16'h0001 : v;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [15:0]   lx_q, lx_d, ly_q, ly_d;
    logic [W-1:0]  opy_q, opy_d, mplier_q, mplier_d;
    logic [AW-1:0] mcand_q, mcand_d, acc_q, acc_d, sum_s;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] total_q, total_d, hits_q, hits_d, n_q, n_d;
    logic          cont_q, cont_d, stop_q, stop_d, busy_q, busy_d, done_q, done_d;
    logic          valid_q, valid_d, hit_q, hit_d, fin_s;

    // Next-state logic for the FSM, LFSRs, squarer datapath and counters.
    always_comb begin
        state_d  = state_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        opy_d    = opy_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        hits_d   = hits_q;
        n_d      = n_q;
        cont_d   = cont_q;
        stop_d   = stop_q;
        busy_d   = busy_q;
        done_d   = done_q;
        valid_d  = 1'b0;
        hit_d    = hit_q;
        fin_s    = 1'b0;
        sum_s    = acc_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});
        if (state_q == S_IDLE || state_q == S_DONE) begin
            // Idle-time controls are honoured even while hold is asserted.
            if (seed_load_i) begin
                lx_d = seed_fix(seed_i);
                ly_d = seed_fix({seed_i[7:0], seed_i[15:8]} ^ 16'h5A5A);
            end else begin
                lx_d = lx_q;
                ly_d = ly_q;
            end
            if (start_i) begin
                total_d = {CW{1'b0}};
                hits_d  = {CW{1'b0}};
                cont_d  = cont_i;
                n_d     = n_samples_i;
                stop_d  = 1'b0;
                if (!cont_i && n_samples_i == {CW{1'b0}}) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end else begin
                state_d = state_q;
            end
        end else if (hold_i) begin
            valid_d = valid_q;
            stop_d  = stop_q | (cont_q & stop_i);
        end else begin
            stop_d = stop_q | (cont_q & stop_i);
            case (state_q)
                S_LOAD: begin
                    mplier_d = force_en_i ? force_x_i : lx_q[15:16-W];
                    mcand_d  = {{(W+1){1'b0}}, (force_en_i ? force_x_i : lx_q[15:16-W])};
                    opy_d    = force_en_i ? force_y_i : ly_q[15:16-W];
                    acc_d    = {AW{1'b0}};
                    cnt_d    = 4'd0;
                    lx_d     = lfsr_step(lx_q);
                    ly_d     = lfsr_step(ly_q);
                    state_d  = S_SQX;
                end
                S_SQX, S_SQY: begin
                    acc_d    = sum_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'(W - 1)) begin
                        cnt_d = 4'd0;
                        if (state_q == S_SQX) begin
                            mcand_d  = {{(W+1){1'b0}}, opy_q};
                            mplier_d = opy_q;
                            state_d  = S_SQY;
                        end else begin
                            // Result is published on entry to CMP so it is visible during CMP.
                            state_d = S_CMP;
                            valid_d = 1'b1;
                            hit_d   = ~sum_s[AW-1];
                            total_d = total_q + {{(CW-1){1'b0}}, 1'b1};
                            hits_d  = hits_q + {{(CW-1){1'b0}}, ~sum_s[AW-1]};
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_CMP: begin
                    if (cont_q) begin
                        fin_s = stop_q | stop_i | (total_q == {CW{1'b1}});
                    end else begin
                        fin_s = (total_q == n_q);
                    end
                    if (fin_s) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lx_q     <= 16'h0001;
            ly_q     <= 16'h5B5A;
            opy_q    <= {W{1'b0}};
            mplier_q <= {W{1'b0}};
            mcand_q  <= {AW{1'b0}};
            acc_q    <= {AW{1'b0}};
            cnt_q    <= 4'd0;
            total_q  <= {CW{1'b0}};
            hits_q   <= {CW{1'b0}};
            n_q      <= {CW{1'b0}};
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            opy_q    <= opy_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            hits_q   <= hits_d;
            n_q      <= n_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign total_o        = total_q;
    assign hits_o         = hits_q;
    assign sample_valid_o = valid_q & ~hold_i;
    assign sample_hit_o   = hit_q;
endmodule

// File: tb/tb_mc_pi_sampler.sv
// Scoreboard bench for mc_pi_sampler: expected samples come from an arithmetic model of
// the LFSR/circle rules and are popped by a monitor on every sample_valid pulse.
module tb_mc_pi_sampler;
    localparam int W  = 8;
    localparam int CW = 16;
    localparam int SL = 2 * W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, cont, stop, hold, seed_load, force_en, start4;
    logic [CW-1:0] n_samples;
    logic [15:0] seed;
    logic [W-1:0] force_x, force_y;
    logic busy, done, sample_valid, sample_hit;
    logic [CW-1:0] total, hits;
    logic busy4, done4, sv4, sh4;
    logic [3:0] total4, hits4;

    mc_pi_sampler #(.W(W), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .stop_i(stop),
        .hold_i(hold), .n_samples_i(n_samples), .seed_load_i(seed_load), .seed_i(seed),
        .force_en_i(force_en), .force_x_i(force_x), .force_y_i(force_y),
        .busy_o(busy), .done_o(done), .total_o(total), .hits_o(hits),
        .sample_valid_o(sample_valid), .sample_hit_o(sample_hit));

    mc_pi_sampler #(.W(W), .CW(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .cont_i(cont), .stop_i(stop),
        .hold_i(hold), .n_samples_i(n_samples[3:0]), .seed_load_i(1'b0), .seed_i(seed),
        .force_en_i(force_en), .force_x_i(force_x), .force_y_i(force_y),
        .busy_o(busy4), .done_o(done4), .total_o(total4), .hits_o(hits4),
        .sample_valid_o(sv4), .sample_hit_o(sh4));

    typedef struct { int hit; int tot; int hts; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int pulses = 0, first_valid = -1, cyc = 0;
    logic [15:0] mlx, mly;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_seed(input logic [15:0] s);
        logic [15:0] t;
        t = {s[7:0], s[15:8]} ^ 16'h5A5A;
        mlx = (s == 16'h0000) ? 16'h0001 : s;
        mly = (t == 16'h0000) ? 16'h0001 : t;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every published sample is compared against the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            pulses++;
            if (first_valid < 0) first_valid = cyc;
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sample_hit", int'(sample_hit), e.hit);
                chk("total_at_valid", int'(total), e.tot);
                chk("hits_at_valid", int'(hits), e.hts);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_seed(16'h0001);
    endtask

    // One run: ne expected samples, optional seed, stop/hold/reset/restart injections at
    // cycle offsets counted in edges after the start edge.
    task automatic run(input int n, input bit c, input bit fen, input int fx, input int fy,
                       input bit dsd, input logic [15:0] sd, input int ne, input int exp_lat,
                       input int exp_fv, input int stop_at, input int hold_at, input int hold_len,
                       input int rst_at, input int bstart_at, input string tag);
        int x, y, hit, etot, eh, d, e0;
        @(negedge clk);
        if (dsd) begin
            seed = sd;
            seed_load = 1'b1;
            model_seed(sd);
        end
        cont = c; n_samples = CW'(n); force_en = fen;
        force_x = W'(fx); force_y = W'(fy);
        start = 1'b1;
        etot = 0; eh = 0;
        for (int i = 0; i < ne; i++) begin
            x = fen ? fx : int'(mlx >> (16 - W));
            y = fen ? fy : int'(mly >> (16 - W));
            mlx = lfsr_next(mlx);
            mly = lfsr_next(mly);
            hit = (x * x + y * y < (1 << (2 * W))) ? 1 : 0;
            etot++; eh += hit;
            q.push_back('{hit, etot, eh});
        end
        pulses = 0; first_valid = -1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        e0 = cyc; d = 0;
        while (!done && d < exp_lat + 60) begin
            if (d == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; stop = 1'b0; hold = 1'b0;
                chk({tag, "_rst_busy"}, int'(busy), 0);
                chk({tag, "_rst_total"}, int'(total), 0);
                chk({tag, "_rst_hits"}, int'(hits), 0);
                chk({tag, "_rst_valid"}, int'(sample_valid), 0);
                q.delete();
                model_seed(16'h0001);
                return;
            end
            stop = (d == stop_at);
            hold = (hold_at >= 0 && d >= hold_at && d < hold_at + hold_len);
            if (d == bstart_at) begin
                start = 1'b1; n_samples = CW'(n + 7); cont = ~c;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            d++;
        end
        stop = 1'b0; hold = 1'b0; start = 1'b0;
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_latency"}, d, exp_lat);
        chk({tag, "_total"}, int'(total), etot);
        chk({tag, "_hits"}, int'(hits), eh);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pulses"}, pulses, ne);
        chk({tag, "_queue_left"}, q.size(), 0);
        if (exp_fv >= 0) chk({tag, "_first_valid"}, first_valid - e0, exp_fv);
    endtask

    initial begin
        int h1, d, ex4, x, y;
        logic [15:0] ax, ay;
        rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0; hold = 1'b0;
        seed_load = 1'b0; force_en = 1'b0; start4 = 1'b0;
        n_samples = '0; seed = '0; force_x = '0; force_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_seed(16'h0001);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_total", int'(total), 0);
        chk("reset_hits", int'(hits), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_hit", int'(sample_hit), 0);

        // Forced boundary points.
        run(1, 0, 1, 181, 181, 0, 16'h0, 1, SL, SL - 1, -1, -1, 0, -1, -1, "f181_181");
        run(1, 0, 1, 181, 182, 0, 16'h0, 1, SL, -1, -1, -1, 0, -1, -1, "f181_182");
        run(1, 0, 1, 255, 255, 0, 16'h0, 1, SL, -1, -1, -1, 0, -1, -1, "f255_255");
        run(1, 0, 1, 0, 0, 0, 16'h0, 1, SL, -1, -1, -1, 0, -1, -1, "f0_0");
        repeat (3) @(negedge clk);
        chk("done_sticky", int'(done), 1);

        // Reproducible batch from reset.
        do_reset();
        run(100, 0, 0, 0, 0, 0, 16'h0, 100, 100 * SL, SL - 1, -1, -1, 0, -1, -1, "batch1");
        h1 = int'(hits);
        do_reset();
        run(100, 0, 0, 0, 0, 0, 16'h0, 100, 100 * SL, -1, -1, -1, 0, -1, -1, "batch2");
        chk("batch_repeat_hits", int'(hits), h1);

        // Edge cases.
        run(0, 0, 0, 0, 0, 0, 16'h0, 0, 0, -1, -1, -1, 0, -1, -1, "n_zero");
        run(2, 0, 0, 0, 0, 1, 16'h0000, 2, 2 * SL, -1, -1, -1, 0, -1, -1, "seed_zero");
        run(3, 0, 0, 0, 0, 0, 16'h0, 3, 3 * SL, -1, -1, -1, 0, -1, 20, "start_busy");
        for (int i = 0; i < 4; i++) begin
            int nn;
            nn = int'($urandom_range(1, 12));
            run(nn, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1, 16'($urandom), nn, nn * SL,
                -1, -1, -1, 0, -1, -1, "random");
        end

        // Continuous mode stopped during SQX of the 5th sample.
        run(0, 1, 0, 0, 0, 0, 16'h0, 5, 5 * SL, -1, 4 * SL + 3, -1, 0, -1, -1, "cont_stop");

        // Hold for 10 cycles inside the first sample, then reset during SQY.
        run(2, 0, 0, 0, 0, 0, 16'h0, 2, 2 * SL + 10, SL - 1 + 10, -1, 5, 10, -1, -1, "hold");
        run(3, 0, 0, 0, 0, 0, 16'h0, 3, 3 * SL, -1, -1, -1, 0, 12, -1, "rst_sqy");

        // Narrow-counter instance: a continuous run halts at the counter ceiling.
        ax = 16'h0001; ay = 16'h5B5A; ex4 = 0;
        for (int i = 0; i < 15; i++) begin
            x = int'(ax >> 8); y = int'(ay >> 8);
            if (x * x + y * y < 65536) ex4++;
            ax = lfsr_next(ax); ay = lfsr_next(ay);
        end
        @(negedge clk);
        cont = 1'b1; force_en = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; cont = 1'b0; d = 0;
        while (!done4 && d < 15 * SL + 60) begin
            @(negedge clk);
            d++;
        end
        chk("cw4_done", int'(done4), 1);
        chk("cw4_latency", d, 15 * SL);
        chk("cw4_total", int'(total4), 15);
        chk("cw4_hits", int'(hits4), ex4);
        chk("cw4_busy", int'(busy4), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
